// File: rtl/axi_slave_default_if.sv
// AXI bus bundle shared by interconnect ports; S is the slave-side view.
interface AXI_INF #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     WR_ADDR_ID;
    logic [ADDR_WIDTH-1:0]   WR_ADDR;
    logic [7:0]              WR_ADDR_LEN;
    logic [1:0]              WR_ADDR_BURST;
    logic                    WR_ADDR_VALID;
    logic                    WR_ADDR_READY;
    logic [DATA_WIDTH-1:0]   WR_DATA;
    logic [DATA_WIDTH/8-1:0] WR_STRB;
    logic                    WR_DATA_LAST;
    logic                    WR_DATA_VALID;
    logic                    WR_DATA_READY;
    logic [ID_WIDTH-1:0]     WR_BACK_ID;
    logic [1:0]              WR_BACK_RESP;
    logic                    WR_BACK_VALID;
    logic                    WR_BACK_READY;
    logic [ID_WIDTH-1:0]     RD_ADDR_ID;
    logic [ADDR_WIDTH-1:0]   RD_ADDR;
    logic [7:0]              RD_ADDR_LEN;
    logic [1:0]              RD_ADDR_BURST;
    logic                    RD_ADDR_VALID;
    logic                    RD_ADDR_READY;
    logic [ID_WIDTH-1:0]     RD_BACK_ID;
    logic [DATA_WIDTH-1:0]   RD_DATA;
    logic [1:0]              RD_DATA_RESP;
    logic                    RD_DATA_LAST;
    logic                    RD_DATA_VALID;
    logic                    RD_DATA_READY;

    modport S (
        input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
        input  WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID, WR_BACK_READY,
        input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID, RD_DATA_READY,
        output WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        output RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID
    );

    modport M (
        output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
        output WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID, WR_BACK_READY,
        output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID, RD_DATA_READY,
        input  WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        input  RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID
    );
endinterface

// File: rtl/axi_slave_default.sv
// Default responder for an unconnected AXI slave port: accepts every burst and
// answers with a fixed error code; write and read sides are independent FSMs.
module axi_slave_default #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [1:0]  RESP_CODE  = 2'b11,
    parameter logic [31:0] FILL_DATA  = 32'hDEAD_BEEF
) (
    input  logic clk,
    input  logic rst,
    AXI_INF.S    AXI_S,
    output logic proto_err
);
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = DATA_WIDTH'(FILL_DATA);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t            w_state;
    r_state_t            r_state;
    logic [ID_WIDTH-1:0] wid;
    logic [7:0]          wlen;
    logic [7:0]          wcnt;
    logic [ID_WIDTH-1:0] rid;
    logic [7:0]          rlen;
    logic [7:0]          rcnt;
    logic                w_final;

    logic unused_inputs;
    assign unused_inputs = ^{AXI_S.WR_ADDR, AXI_S.WR_ADDR_BURST, AXI_S.WR_DATA,
                             AXI_S.WR_STRB, AXI_S.RD_ADDR, AXI_S.RD_ADDR_BURST};

    always_comb begin
        w_final = (wcnt == wlen);
    end

    // Write side: the burst ends on the beat count; WR_DATA_LAST is only audited.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state             <= W_IDLE;
            wid                 <= '0;
            wlen                <= '0;
            wcnt                <= '0;
            proto_err           <= 1'b0;
            AXI_S.WR_ADDR_READY <= 1'b0;
            AXI_S.WR_DATA_READY <= 1'b0;
            AXI_S.WR_BACK_ID    <= '0;
            AXI_S.WR_BACK_RESP  <= '0;
            AXI_S.WR_BACK_VALID <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AXI_S.WR_ADDR_READY <= 1'b1;
                    if (AXI_S.WR_ADDR_VALID && AXI_S.WR_ADDR_READY) begin
                        wid                 <= AXI_S.WR_ADDR_ID;
                        wlen                <= AXI_S.WR_ADDR_LEN;
                        wcnt                <= '0;
                        AXI_S.WR_ADDR_READY <= 1'b0;
                        AXI_S.WR_DATA_READY <= 1'b1;
                        w_state             <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (AXI_S.WR_DATA_VALID && AXI_S.WR_DATA_READY) begin
                        if (AXI_S.WR_DATA_LAST != w_final)
                            proto_err <= 1'b1;
                        if (w_final) begin
                            AXI_S.WR_DATA_READY <= 1'b0;
                            AXI_S.WR_BACK_VALID <= 1'b1;
                            AXI_S.WR_BACK_ID    <= wid;
                            AXI_S.WR_BACK_RESP  <= RESP_CODE;
                            w_state             <= W_RESP;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (AXI_S.WR_BACK_VALID && AXI_S.WR_BACK_READY) begin
                        AXI_S.WR_BACK_VALID <= 1'b0;
                        AXI_S.WR_ADDR_READY <= 1'b1;
                        w_state             <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read side: LAST is precomputed for the next beat so it is registered with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= R_IDLE;
            rid                 <= '0;
            rlen                <= '0;
            rcnt                <= '0;
            AXI_S.RD_ADDR_READY <= 1'b0;
            AXI_S.RD_BACK_ID    <= '0;
            AXI_S.RD_DATA       <= '0;
            AXI_S.RD_DATA_RESP  <= '0;
            AXI_S.RD_DATA_LAST  <= 1'b0;
            AXI_S.RD_DATA_VALID <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    AXI_S.RD_ADDR_READY <= 1'b1;
                    if (AXI_S.RD_ADDR_VALID && AXI_S.RD_ADDR_READY) begin
                        rid                 <= AXI_S.RD_ADDR_ID;
                        rlen                <= AXI_S.RD_ADDR_LEN;
                        rcnt                <= '0;
                        AXI_S.RD_ADDR_READY <= 1'b0;
                        AXI_S.RD_DATA_VALID <= 1'b1;
                        AXI_S.RD_BACK_ID    <= AXI_S.RD_ADDR_ID;
                        AXI_S.RD_DATA       <= FILL_WORD;
                        AXI_S.RD_DATA_RESP  <= RESP_CODE;
                        AXI_S.RD_DATA_LAST  <= (AXI_S.RD_ADDR_LEN == 8'd0);
                        r_state             <= R_DATA;
                    end
                end
                R_DATA: begin
                    AXI_S.RD_BACK_ID <= rid;
                    if (AXI_S.RD_DATA_VALID && AXI_S.RD_DATA_READY) begin
                        if (AXI_S.RD_DATA_LAST) begin
                            AXI_S.RD_DATA_VALID <= 1'b0;
                            AXI_S.RD_DATA_LAST  <= 1'b0;
                            AXI_S.RD_ADDR_READY <= 1'b1;
                            r_state             <= R_IDLE;
                        end else begin
                            rcnt               <= rcnt + 8'd1;
                            AXI_S.RD_DATA_LAST <= ((rcnt + 8'd1) == rlen);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_default.sv
// Directed bench for axi_slave_default: reset, write/read bursts, LAST audit, async reset mid-burst.
module tb_axi_slave_default;
    logic clk;
    logic rst;
    logic proto_err;
    int   n_tests;
    int   n_fail;

    AXI_INF #(.ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

    axi_slave_default #(
        .ID_WIDTH(4),
        .DATA_WIDTH(32),
        .RESP_CODE(2'b11),
        .FILL_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .AXI_S(bus.S),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {13'd0, bus.WR_ADDR_READY, bus.WR_DATA_READY, bus.WR_BACK_ID, bus.WR_BACK_RESP,
                bus.WR_BACK_VALID, bus.RD_ADDR_READY, bus.RD_BACK_ID, bus.RD_DATA,
                bus.RD_DATA_RESP, bus.RD_DATA_LAST, bus.RD_DATA_VALID, proto_err};
    endfunction

    function automatic logic [63:0] rd_snap();
        return {24'd0, bus.RD_DATA, bus.RD_DATA_LAST, bus.RD_BACK_ID, bus.RD_DATA_RESP,
                bus.RD_DATA_VALID};
    endfunction

    task automatic clear_inputs();
        bus.WR_ADDR_ID = '0; bus.WR_ADDR = '0; bus.WR_ADDR_LEN = '0; bus.WR_ADDR_BURST = 2'b01;
        bus.WR_ADDR_VALID = 1'b0; bus.WR_DATA = '0; bus.WR_STRB = '1; bus.WR_DATA_LAST = 1'b0;
        bus.WR_DATA_VALID = 1'b0; bus.WR_BACK_READY = 1'b0;
        bus.RD_ADDR_ID = '0; bus.RD_ADDR = '0; bus.RD_ADDR_LEN = '0; bus.RD_ADDR_BURST = 2'b01;
        bus.RD_ADDR_VALID = 1'b0; bus.RD_DATA_READY = 1'b0;
    endtask

    initial begin
        logic [63:0] snap;
        logic        stalled;
        logic        rr;
        logic        done;
        logic        hit;
        logic        w_hs;
        logic        r_hs;
        int          beats;
        int          wbeats;

        n_tests = 0;
        n_fail  = 0;
        clear_inputs();

        // 1. reset
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (5) tick();
        check("rst_outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        check("aw_ready_before_edge", {63'd0, bus.WR_ADDR_READY}, 64'd0);
        tick();
        check("aw_ready_after_rst", {63'd0, bus.WR_ADDR_READY}, 64'd1);
        check("ar_ready_after_rst", {63'd0, bus.RD_ADDR_READY}, 64'd1);

        // 2. write ID=5 LEN=3, slow B channel
        bus.WR_ADDR_ID = 4'd5; bus.WR_ADDR_LEN = 8'd3; bus.WR_ADDR_VALID = 1'b1;
        bus.WR_DATA_VALID = 1'b1; bus.WR_DATA_LAST = 1'b0; bus.WR_DATA = 32'h1111_0000;
        tick();
        bus.WR_ADDR_VALID = 1'b0;
        check("w2_aw_ready_drop", {62'd0, bus.WR_ADDR_READY, bus.WR_DATA_READY}, 64'b01);
        for (int i = 0; i < 4; i++) begin
            bus.WR_DATA_VALID = 1'b1;
            bus.WR_DATA_LAST  = (i == 3);
            bus.WR_DATA       = 32'h1111_0000 + 32'(i);
            if (i == 3)
                check("w2_no_bvalid_early", {63'd0, bus.WR_BACK_VALID}, 64'd0);
            tick();
        end
        bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;
        check("w2_wready_drop", {63'd0, bus.WR_DATA_READY}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("w2_b_hold", {57'd0, bus.WR_BACK_VALID, bus.WR_BACK_ID, bus.WR_BACK_RESP},
                  {57'd0, 1'b1, 4'd5, 2'b11});
            tick();
        end
        check("w2_proto_ok", {63'd0, proto_err}, 64'd0);
        bus.WR_BACK_READY = 1'b1;
        tick();
        bus.WR_BACK_READY = 1'b0;
        check("w2_b_done", {62'd0, bus.WR_BACK_VALID, bus.WR_ADDR_READY}, 64'b01);

        // 3. read ID=2 LEN=0
        bus.RD_ADDR_ID = 4'd2; bus.RD_ADDR_LEN = 8'd0; bus.RD_ADDR_VALID = 1'b1;
        bus.RD_DATA_READY = 1'b1;
        tick();
        bus.RD_ADDR_VALID = 1'b0;
        check("r3_beat", rd_snap(), {24'd0, 32'hDEAD_BEEF, 1'b1, 4'd2, 2'b11, 1'b1});
        check("r3_ar_ready_low", {63'd0, bus.RD_ADDR_READY}, 64'd0);
        tick();
        check("r3_done", {61'd0, bus.RD_DATA_VALID, bus.RD_DATA_LAST, bus.RD_ADDR_READY},
              64'b001);

        // 4. read LEN=255, random RREADY
        bus.RD_ADDR_ID = 4'd9; bus.RD_ADDR_LEN = 8'd255; bus.RD_ADDR_VALID = 1'b1;
        bus.RD_DATA_READY = 1'b0;
        tick();
        bus.RD_ADDR_VALID = 1'b0;
        beats = 0; stalled = 1'b0; done = 1'b0; snap = '0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (stalled)
                check("r4_stall_stable", rd_snap(), snap);
            rr = 1'($urandom_range(0, 1));
            bus.RD_DATA_READY = rr;
            snap    = rd_snap();
            stalled = bus.RD_DATA_VALID && !rr;
            if (bus.RD_DATA_VALID && rr) begin
                check("r4_last_pos", {63'd0, bus.RD_DATA_LAST}, {63'd0, (beats == 255)});
                beats++;
                if (bus.RD_DATA_LAST) done = 1'b1;
            end
            tick();
        end
        bus.RD_DATA_READY = 1'b0;
        check("r4_completed", {63'd0, done}, 64'd1);
        check("r4_beat_count", 64'(beats), 64'd256);
        check("r4_idle", {62'd0, bus.RD_DATA_VALID, bus.RD_ADDR_READY}, 64'b01);

        // 5. write LEN=3 with LAST on beat 2
        bus.WR_ADDR_ID = 4'd1; bus.WR_ADDR_LEN = 8'd3; bus.WR_ADDR_VALID = 1'b1;
        tick();
        bus.WR_ADDR_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w5_wready", {63'd0, bus.WR_DATA_READY}, 64'd1);
            bus.WR_DATA_VALID = 1'b1;
            bus.WR_DATA_LAST  = (i == 1);
            tick();
            if (i == 0) check("w5_proto_before", {63'd0, proto_err}, 64'd0);
            if (i == 1) check("w5_proto_set", {63'd0, proto_err}, 64'd1);
        end
        bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;
        check("w5_b", {57'd0, bus.WR_BACK_VALID, bus.WR_BACK_ID, bus.WR_BACK_RESP},
              {57'd0, 1'b1, 4'd1, 2'b11});
        bus.WR_BACK_READY = 1'b1;
        tick();
        bus.WR_BACK_READY = 1'b0;
        check("w5_b_done", {62'd0, bus.WR_BACK_VALID, proto_err}, 64'b01);

        // 6. concurrent write LEN=7 / read LEN=15, reset during read beat 10
        bus.WR_ADDR_ID = 4'd3; bus.WR_ADDR_LEN = 8'd7; bus.WR_ADDR_VALID = 1'b1;
        bus.RD_ADDR_ID = 4'd4; bus.RD_ADDR_LEN = 8'd15; bus.RD_ADDR_VALID = 1'b1;
        tick();
        bus.WR_ADDR_VALID = 1'b0; bus.RD_ADDR_VALID = 1'b0;
        bus.RD_DATA_READY = 1'b1;
        beats = 0; wbeats = 0; hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (bus.RD_DATA_VALID && beats == 9) begin
                hit = 1'b1;
            end else begin
                bus.WR_DATA_VALID = (wbeats < 8);
                bus.WR_DATA_LAST  = (wbeats == 7);
                w_hs = bus.WR_DATA_VALID && bus.WR_DATA_READY;
                r_hs = bus.RD_DATA_VALID && bus.RD_DATA_READY;
                tick();
                if (w_hs) wbeats++;
                if (r_hs) beats++;
            end
        end
        check("c6_reached_beat10", {63'd0, hit}, 64'd1);
        check("c6_write_beats", 64'(wbeats), 64'd8);
        check("c6_b_pending", {61'd0, bus.WR_BACK_VALID, bus.WR_BACK_ID[1:0]}, 64'b111);
        check("c6_proto_sticky", {63'd0, proto_err}, 64'd1);
        check("c6_rlast_mid", {63'd0, bus.RD_DATA_LAST}, 64'd0);
        rst = 1'b1;
        #1;
        check("c6_async_zero", all_outs(), 64'd0);
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
        check("c6_ready_again", {62'd0, bus.WR_ADDR_READY, bus.RD_ADDR_READY}, 64'b11);

        // fresh concurrent write LEN=1 and read LEN=1
        bus.WR_ADDR_ID = 4'd9; bus.WR_ADDR_LEN = 8'd1; bus.WR_ADDR_VALID = 1'b1;
        bus.RD_ADDR_ID = 4'd6; bus.RD_ADDR_LEN = 8'd1; bus.RD_ADDR_VALID = 1'b1;
        tick();
        bus.WR_ADDR_VALID = 1'b0; bus.RD_ADDR_VALID = 1'b0;
        check("f_wready", {63'd0, bus.WR_DATA_READY}, 64'd1);
        check("f_r_beat1", rd_snap(), {24'd0, 32'hDEAD_BEEF, 1'b0, 4'd6, 2'b11, 1'b1});
        bus.WR_DATA_VALID = 1'b1; bus.WR_DATA_LAST = 1'b0; bus.RD_DATA_READY = 1'b1;
        tick();
        check("f_r_beat2", rd_snap(), {24'd0, 32'hDEAD_BEEF, 1'b1, 4'd6, 2'b11, 1'b1});
        bus.WR_DATA_LAST = 1'b1;
        tick();
        bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0; bus.RD_DATA_READY = 1'b0;
        check("f_b", {57'd0, bus.WR_BACK_VALID, bus.WR_BACK_ID, bus.WR_BACK_RESP},
              {57'd0, 1'b1, 4'd9, 2'b11});
        check("f_r_idle", {62'd0, bus.RD_DATA_VALID, bus.RD_ADDR_READY}, 64'b01);
        check("f_proto_clear", {63'd0, proto_err}, 64'd0);
        bus.WR_BACK_READY = 1'b1;
        tick();
        bus.WR_BACK_READY = 1'b0;
        check("f_b_done", {62'd0, bus.WR_BACK_VALID, bus.WR_ADDR_READY}, 64'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
